// File: rtl/fpu_pkg.sv
// Shared constants and state encoding for the bit-serial FPU front end.
package fpu_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;

    localparam logic [WORD_W-1:0] CANONICAL_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_UNLOAD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fpu_serial_if_if.sv
// Parallel handshake bus between the serial collector (master) and the FPU core (slave).
interface fpu_serial_if_if;
    import fpu_pkg::*;

    logic [WORD_W-1:0] o_fpu_a;
    logic [WORD_W-1:0] o_fpu_b;
    logic [2:0]        o_fpu_op;
    logic              o_fpu_valid;
    logic              i_fpu_ready;
    logic [WORD_W-1:0] i_fpu_result;

    modport master (
        output o_fpu_a, o_fpu_b, o_fpu_op, o_fpu_valid,
        input  i_fpu_ready, i_fpu_result
    );

    modport slave (
        input  o_fpu_a, o_fpu_b, o_fpu_op, o_fpu_valid,
        output i_fpu_ready, i_fpu_result
    );

endinterface

// File: rtl/fpu_shift_reg.sv
// 32-bit right-shift register: parallel load wins over shift, serial bit enters at the MSB.
module fpu_shift_reg
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [WORD_W-1:0] load_val,
    input  logic              shift_en,
    input  logic              ser_in,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] data_q, data_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        data_d = data_q;
        if (load_en) begin
            data_d = load_val;
        end else if (shift_en) begin
            data_d = {ser_in, data_q[WORD_W-1:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/fpu_serial_if.sv
// Bit-serial operand collector / result serializer in front of the FPU core.
// Optional WAIT watchdog (parameter TIMEOUT_CYCLES) is built when FPU_SERIAL_TIMEOUT_EN is defined.
module fpu_serial_if
    import fpu_pkg::*;
`ifdef FPU_SERIAL_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 15
)
`endif
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [2:0]             i_funct,
    input  logic                   i_en,
    input  logic                   i_rs1,
    input  logic                   i_rs2,
    output logic                   o_rd,
    output logic                   o_rd_valid,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_timeout,
    fpu_serial_if_if.master        fpu
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         funct_q, funct_d;
    logic               op_shift;
    logic               res_shift;
    logic               res_load;
    logic [WORD_W-1:0]  res_load_val;
    logic [WORD_W-1:0]  a_q, b_q, res_q;

`ifdef FPU_SERIAL_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct_d      = funct_q;
        op_shift     = 1'b0;
        res_shift    = 1'b0;
        res_load     = 1'b0;
        res_load_val = fpu.i_fpu_result;
`ifdef FPU_SERIAL_TIMEOUT_EN
        wd_d         = wd_q;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    funct_d = i_funct;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (i_en) begin
                    op_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    // Counter wraps to 0 on the 32nd beat, ready for UNLOAD.
                    if (cnt_q == CNT_W'(WORD_W - 1)) state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef FPU_SERIAL_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu.i_fpu_ready) begin
                    res_load = 1'b1;
                    state_d  = ST_UNLOAD;
                end
`ifdef FPU_SERIAL_TIMEOUT_EN
                else if (wd_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    res_load     = 1'b1;
                    res_load_val = CANONICAL_NAN;
                    timeout_d    = 1'b1;
                    state_d      = ST_UNLOAD;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end
            ST_UNLOAD: begin
                if (i_en) begin
                    res_shift = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WORD_W - 1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            funct_q <= funct_d;
        end
    end

`ifdef FPU_SERIAL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    fpu_shift_reg u_a (
        .clk      (clk),
        .rst      (rst),
        .load_en  (1'b0),
        .load_val ('0),
        .shift_en (op_shift),
        .ser_in   (i_rs1),
        .q        (a_q)
    );

    fpu_shift_reg u_b (
        .clk      (clk),
        .rst      (rst),
        .load_en  (1'b0),
        .load_val ('0),
        .shift_en (op_shift),
        .ser_in   (i_rs2),
        .q        (b_q)
    );

    fpu_shift_reg u_res (
        .clk      (clk),
        .rst      (rst),
        .load_en  (res_load),
        .load_val (res_load_val),
        .shift_en (res_shift),
        .ser_in   (1'b0),
        .q        (res_q)
    );

    // The FPU re-latches on every valid cycle, so valid is a pure ISSUE decode.
    assign fpu.o_fpu_valid = (state_q == ST_ISSUE);
    assign fpu.o_fpu_a     = a_q;
    assign fpu.o_fpu_b     = b_q;
    assign fpu.o_fpu_op    = funct_q;

    assign o_rd       = res_q[0];
    assign o_rd_valid = (state_q == ST_UNLOAD);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_fpu_serial_if.sv
// Directed bench for fpu_serial_if with a latency-programmable FPU responder.
module tb_fpu_serial_if;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [2:0]  i_funct = 3'b000;
    logic        i_en = 1'b0;
    logic        i_rs1 = 1'b0;
    logic        i_rs2 = 1'b0;
    logic        o_rd, o_rd_valid, o_busy, o_done, o_timeout;

    fpu_serial_if_if fpu_bus ();

    fpu_serial_if dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_funct    (i_funct),
        .i_en       (i_en),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .o_rd       (o_rd),
        .o_rd_valid (o_rd_valid),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_timeout  (o_timeout),
        .fpu        (fpu_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Results of the most recent run_op
    logic [31:0] op_rd, op_a, op_b;
    logic [2:0]  op_op;
    int          op_valid_cnt, op_done_cnt, op_wait_len, op_latency;

    // lat = 0 means the FPU model never answers.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                          input logic [31:0] res, input int lat, input bit gaps, input bit poke);
        int  idx, t_start, t_valid, t_rdv, t_done;
        bit  done_seen;
        idx = 0; t_valid = -1; t_rdv = -1; t_done = -1; done_seen = 0;
        op_rd = '0; op_a = '0; op_b = '0; op_op = '0;
        op_valid_cnt = 0; op_done_cnt = 0;
        fpu_bus.i_fpu_result = res;

        @(negedge clk);
        i_start = 1'b1; i_funct = f; i_en = 1'b1; i_rs1 = 1'b1; i_rs2 = 1'b1;
        t_start = cyc;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                i_en = 1'b0;
                if (poke) begin i_start = 1'b1; i_funct = 3'b111; end
                @(negedge clk);
                i_start = 1'b0;
            end
            i_en = 1'b1; i_rs1 = a[i]; i_rs2 = b[i];
            @(negedge clk);
        end
        i_en = 1'b0;

        for (int k = 0; k < 400 && !done_seen; k++) begin
            if (fpu_bus.o_fpu_valid) begin
                op_valid_cnt++;
                t_valid = cyc;
                op_a = fpu_bus.o_fpu_a; op_b = fpu_bus.o_fpu_b; op_op = fpu_bus.o_fpu_op;
            end
            fpu_bus.i_fpu_ready = (lat > 0 && t_valid >= 0 && cyc == t_valid + lat);
            if (o_rd_valid) begin
                if (t_rdv < 0) t_rdv = cyc;
                if (i_en && idx < 32) begin op_rd[idx] = o_rd; idx++; end
            end
            if (o_done) begin op_done_cnt++; t_done = cyc; done_seen = 1; end
            i_en    = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_start = poke && o_busy && !o_done && ($urandom_range(0, 3) == 0);
            i_funct = 3'b111;
            @(negedge clk);
        end
        i_en = 1'b0; i_start = 1'b0; fpu_bus.i_fpu_ready = 1'b0;
        if (o_done) op_done_cnt++;
        if (!done_seen) check("op_reached_done", 32'd0, 32'd1);
        op_wait_len = t_rdv - t_valid - 1;
        op_latency  = t_done - t_start + 1;
    endtask

    initial begin
        fpu_bus.i_fpu_ready  = 1'b0;
        fpu_bus.i_fpu_result = '0;

        // Reset values while rst is held
        #12;
        check("rst_busy",    {31'd0, o_busy},     32'd0);
        check("rst_rd",      {31'd0, o_rd},       32'd0);
        check("rst_rdvalid", {31'd0, o_rd_valid}, 32'd0);
        check("rst_done",    {31'd0, o_done},     32'd0);
        check("rst_timeout", {31'd0, o_timeout},  32'd0);
        check("rst_valid",   {31'd0, fpu_bus.o_fpu_valid}, 32'd0);
        check("rst_fpu_a",   fpu_bus.o_fpu_a, 32'd0);
        check("rst_fpu_b",   fpu_bus.o_fpu_b, 32'd0);
        check("rst_fpu_op",  {29'd0, fpu_bus.o_fpu_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // add: 1.0 + 2.0 = 3.0, latency 2
        run_op(32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000, 2, 1'b0, 1'b0);
        check("add_rd",      op_rd, 32'h4040_0000);
        check("add_valid1",  op_valid_cnt, 32'd1);
        check("add_done1",   op_done_cnt,  32'd1);
        check("add_a",       op_a, 32'h3F80_0000);
        check("add_b",       op_b, 32'h4000_0000);
        check("add_op",      {29'd0, op_op}, {29'd0, OP_ADD});
        check("add_wait",    op_wait_len, 32'd2);
        check("add_latency", op_latency, 32'd69);
        check("add_idle",    {31'd0, o_busy}, 32'd0);

        // mul: 2.0 * 3.0 = 6.0, latency 3
        run_op(32'h4000_0000, 32'h4040_0000, OP_MUL, 32'h40C0_0000, 3, 1'b0, 1'b0);
        check("mul_rd",   op_rd, 32'h40C0_0000);
        check("mul_wait", op_wait_len, 32'd3);
        check("mul_op",   {29'd0, op_op}, {29'd0, OP_MUL});

        // div corner: 1.0 / 0.0 = +inf, latency 1
        run_op(32'h3F80_0000, 32'h0000_0000, OP_DIV, 32'h7F80_0000, 1, 1'b0, 1'b0);
        check("div_rd",   op_rd, 32'h7F80_0000);
        check("div_wait", op_wait_len, 32'd1);
        check("div_b",    op_b, 32'h0000_0000);

        // unsupported opcode passes through unchanged
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 3'b111, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
        check("unsup_op", {29'd0, op_op}, 32'd7);
        check("unsup_rd", op_rd, 32'hFFFF_FFFF);

        // sub with random i_en gaps and stray i_start pulses while busy
        run_op(32'h4040_0000, 32'h3F80_0000, OP_SUB, 32'h4000_0000, 2, 1'b1, 1'b1);
        check("gap_rd",    op_rd, 32'h4000_0000);
        check("gap_a",     op_a, 32'h4040_0000);
        check("gap_b",     op_b, 32'h3F80_0000);
        check("gap_op",    {29'd0, op_op}, {29'd0, OP_SUB});
        check("gap_valid", op_valid_cnt, 32'd1);
        check("gap_done",  op_done_cnt, 32'd1);

        // reset after 17 LOAD beats
        @(negedge clk);
        i_start = 1'b1; i_funct = OP_MUL;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            i_en = 1'b1; i_rs1 = 1'b1; i_rs2 = 1'b1;
            @(negedge clk);
        end
        i_en = 1'b0;
        check("mid_busy_pre", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_busy",    {31'd0, o_busy}, 32'd0);
        check("mid_fpu_a",   fpu_bus.o_fpu_a, 32'd0);
        check("mid_fpu_b",   fpu_bus.o_fpu_b, 32'd0);
        check("mid_fpu_op",  {29'd0, fpu_bus.o_fpu_op}, 32'd0);
        check("mid_rdvalid", {31'd0, o_rd_valid}, 32'd0);
        check("mid_done",    {31'd0, o_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // late FPU ready while idle is ignored
        fpu_bus.i_fpu_ready = 1'b1;
        @(negedge clk);
        fpu_bus.i_fpu_ready = 1'b0;
        @(negedge clk);
        check("stray_ready_idle", {31'd0, o_busy}, 32'd0);

        run_op(32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000, 2, 1'b0, 1'b0);
        check("post_rst_rd",   op_rd, 32'h4040_0000);
        check("post_rst_done", op_done_cnt, 32'd1);

`ifdef FPU_SERIAL_TIMEOUT_EN
        run_op(32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000, 0, 1'b0, 1'b0);
        check("to_rd",   op_rd, CANONICAL_NAN);
        check("to_wait", op_wait_len, 32'd15);
        check("to_flag", {31'd0, o_timeout}, 32'd1);
        run_op(32'h4000_0000, 32'h4040_0000, OP_MUL, 32'h40C0_0000, 3, 1'b0, 1'b0);
        check("to_sticky", {31'd0, o_timeout}, 32'd1);
        check("to_next_rd", op_rd, 32'h40C0_0000);
        rst = 1'b1;
        #1;
        check("to_clear", {31'd0, o_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
